// File: rtl/pool_scheduler.sv
// pool_scheduler: round-robin time-sharing of one max-pooling engine among NCH feature-map channels
module pool_scheduler #(
    parameter int NCH = 4,
    parameter int M = 12,
    parameter int P = 3,
    parameter int WIDTH = 32,
    parameter int DRAIN_TO = 64
) (
    input  logic                     clk,
    input  logic                     master_rst,
    input  logic [NCH-1:0]           req,
    input  logic [NCH*WIDTH-1:0]     in_data,
    input  logic [NCH-1:0]           in_valid,
    output logic [NCH-1:0]           in_ready,
    output logic                     pl_rst,
    output logic                     pl_ce,
    output logic [WIDTH-1:0]         pl_data_in,
    input  logic [WIDTH-1:0]         pl_data_out,
    input  logic                     pl_valid_op,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    output logic [$clog2(NCH)-1:0]   out_ch,
    output logic                     out_last,
    output logic                     busy,
    output logic                     err
);
    localparam int CW = $clog2(NCH);
    localparam int MM = M * M;
    localparam int NOUT = (M / P) * (M / P);
    localparam int IW = $clog2(MM + 1);
    localparam int OW = $clog2(NOUT + 1);
    localparam int DW = $clog2(DRAIN_TO + 1);
    typedef enum logic [1:0] {IDLE, CLR, RUN, DRAIN} state_t;
    state_t state, state_n;
    logic [CW-1:0] rr_ptr, gnt, pick, gnt_inc;
    logic [IW-1:0] in_cnt;
    logic [OW-1:0] out_cnt;
    logic [DW-1:0] drain_cnt;
    logic take, cap, done, timeout;
    always_comb begin
        pick = rr_ptr;
        for (int i = NCH - 1; i >= 0; i--) if (req[i]) pick = CW'(i);
        for (int i = NCH - 1; i >= 0; i--) if (req[i] && CW'(i) >= rr_ptr) pick = CW'(i);
    end
    assign gnt_inc = (gnt == CW'(NCH - 1)) ? '0 : gnt + 1'b1;
    assign take = state == RUN && in_valid[gnt];
    assign done = out_cnt == OW'(NOUT);
    assign cap = (state == RUN || state == DRAIN) && pl_valid_op && !done;
    assign timeout = state == DRAIN && !done && drain_cnt == DW'(DRAIN_TO - 1);
    assign pl_rst = master_rst || state == CLR;
    assign busy = state != IDLE;
    always_comb begin
        state_n = state;
        in_ready = '0;
        pl_ce = 1'b0;
        pl_data_in = '0;
        case (state)
            IDLE: state_n = |req ? CLR : IDLE;
            CLR: state_n = RUN;
            RUN: begin
                in_ready[gnt] = 1'b1;
                pl_ce = in_valid[gnt];
                pl_data_in = in_data[gnt*WIDTH +: WIDTH];
                state_n = (take && in_cnt == IW'(MM - 1)) ? DRAIN : RUN;
            end
            default: begin
                pl_ce = 1'b1;
                state_n = (done || timeout) ? IDLE : DRAIN;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (master_rst) begin
            state <= IDLE;
            rr_ptr <= '0;
            gnt <= '0;
            in_cnt <= '0;
            out_cnt <= '0;
            drain_cnt <= '0;
            out_data <= '0;
            out_valid <= 1'b0;
            out_ch <= '0;
            out_last <= 1'b0;
            err <= 1'b0;
        end else begin
            state <= state_n;
            out_valid <= cap;
            out_last <= cap && out_cnt == OW'(NOUT - 1);
            if (state == IDLE && |req) gnt <= pick;
            if (state == CLR) begin
                in_cnt <= '0;
                out_cnt <= '0;
                drain_cnt <= '0;
            end
            if (take) in_cnt <= in_cnt + 1'b1;
            if (cap) begin
                out_data <= pl_data_out;
                out_ch <= gnt;
                out_cnt <= out_cnt + 1'b1;
            end
            if (state == DRAIN) drain_cnt <= drain_cnt + 1'b1;
            if (state == DRAIN && state_n == IDLE) rr_ptr <= gnt_inc;
            if (timeout) err <= 1'b1;
        end
    end
endmodule
